// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token characters and the word-alignment
// state encoding. The TMDS encoder uses the same token constants.
package tmds_pkg;

  // Control-period characters, written bit9..bit0, one per {C1,C0} value
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Word-alignment states
  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT = 2'd1,
    VERIFY    = 2'd2,
    LOCKED    = 2'd3
  } alignState_t;

endpackage

// File: rtl/tmds_decoder_aligner_if.sv
// Character stream into the decoder/aligner and the decoded results back out.
// The master side is the deserializer/consumer, the slave side is the decoder.
interface tmds_decoder_aligner_if;

  logic [9:0] tmdsCharacterIn;
  logic [7:0] pixelComponent;
  logic [1:0] controlBus;
  logic       DE;
  logic       bitslip;
  logic       locked;

  modport master (
    output tmdsCharacterIn,
    input  pixelComponent,
    input  controlBus,
    input  DE,
    input  bitslip,
    input  locked
  );

  modport slave (
    input  tmdsCharacterIn,
    output pixelComponent,
    output controlBus,
    output DE,
    output bitslip,
    output locked
  );

endinterface

// File: rtl/tmds_char_decode.sv
// Purely combinational decode of one 10-bit TMDS character: recognises the
// four control tokens and undoes the XOR/XNOR and inversion steps for data.
module tmds_char_decode
  import tmds_pkg::*;
(
  input  logic [9:0] character,
  output logic [7:0] data,
  output logic [1:0] control,
  output logic       isControl
);

  logic [7:0] unInverted;

  // Token match and data-character decode
  always_comb begin
    isControl = 1'b0;
    control   = 2'b00;
    case (character)
      CTRL_TOKEN_00: begin isControl = 1'b1; control = 2'b00; end
      CTRL_TOKEN_01: begin isControl = 1'b1; control = 2'b01; end
      CTRL_TOKEN_10: begin isControl = 1'b1; control = 2'b10; end
      CTRL_TOKEN_11: begin isControl = 1'b1; control = 2'b11; end
      default:       begin isControl = 1'b0; control = 2'b00; end
    endcase

    unInverted = character[9] ? ~character[7:0] : character[7:0];

    data    = 8'h00;
    data[0] = unInverted[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = character[8] ? (unInverted[i] ^ unInverted[i-1])
                             : ~(unInverted[i] ^ unInverted[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder_aligner.sv
// TMDS channel decoder with word-alignment search. The incoming character is
// registered once; the alignment FSM and the decoder both work from that
// register, and decoded outputs are registered again (2-cycle latency).
// Decoded outputs are held at zero whenever the channel is not locked.
module tmds_decoder_aligner
  import tmds_pkg::*;
#(
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOCK_TOKENS   = 16,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic                   pixelClock,
  input  logic                   resetN,
  tmds_decoder_aligner_if.slave  bus
);

  localparam int IDLE_W   = $clog2(SEARCH_WINDOW) + 1;
  localparam int SETTLE_W = $clog2(SLIP_SETTLE) + 1;
  localparam int TOKEN_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int LOSS_W   = $clog2(LOSS_WINDOW) + 1;

  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(SEARCH_WINDOW - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);
  localparam logic [TOKEN_W-1:0]  TOKEN_LAST  = TOKEN_W'(LOCK_TOKENS - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_WINDOW - 1);

  logic [9:0]          charReg;
  alignState_t         state;
  logic [IDLE_W-1:0]   idleCount;
  logic [SETTLE_W-1:0] settleCount;
  logic [TOKEN_W-1:0]  tokenCount;
  logic [LOSS_W-1:0]   lossCount;
  logic                bitslipReg;
  logic                lockedReg;

  logic [7:0] decData;
  logic [1:0] decControl;
  logic       decIsControl;

  logic       lockEnter;
  logic       lockDrop;
  logic       lockedNext;

  logic [7:0] pixelReg;
  logic [1:0] controlReg;
  logic       deReg;

  tmds_char_decode charDecode (
    .character (charReg),
    .data      (decData),
    .control   (decControl),
    .isControl (decIsControl)
  );

  // Capture the deserializer word; everything downstream uses this copy
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      charReg <= 10'd0;
    end else begin
      charReg <= bus.tmdsCharacterIn;
    end
  end

  // Lock transitions for this cycle, shared by the FSM and the output gating
  always_comb begin
    lockEnter  = (state == VERIFY) && decIsControl && (tokenCount == TOKEN_LAST);
    lockDrop   = (state == LOCKED) && !decIsControl && (lossCount == LOSS_LAST);
    lockedNext = lockEnter || (lockedReg && !lockDrop);
  end

  // Alignment FSM: hunt for control tokens, slip when none appear, confirm a
  // run of tokens before locking, and fall back to searching on a long silence
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state       <= SEARCH;
      idleCount   <= '0;
      settleCount <= '0;
      tokenCount  <= '0;
      lossCount   <= '0;
      bitslipReg  <= 1'b0;
      lockedReg   <= 1'b0;
    end else begin
      bitslipReg <= 1'b0;
      lockedReg  <= lockedNext;
      case (state)
        SEARCH: begin
          if (decIsControl) begin
            state      <= VERIFY;
            tokenCount <= TOKEN_W'(1);
            idleCount  <= '0;
          end else if (idleCount == IDLE_LAST) begin
            state       <= SLIP_WAIT;
            bitslipReg  <= 1'b1;
            idleCount   <= '0;
            settleCount <= '0;
          end else begin
            idleCount <= (idleCount == '1) ? idleCount : idleCount + 1'b1;
          end
        end
        SLIP_WAIT: begin
          if (settleCount == SETTLE_LAST) begin
            state       <= SEARCH;
            settleCount <= '0;
            idleCount   <= '0;
          end else begin
            settleCount <= (settleCount == '1) ? settleCount : settleCount + 1'b1;
          end
        end
        VERIFY: begin
          if (!decIsControl) begin
            state      <= SEARCH;
            idleCount  <= '0;
            tokenCount <= '0;
          end else if (lockEnter) begin
            state      <= LOCKED;
            tokenCount <= '0;
            lossCount  <= '0;
          end else begin
            tokenCount <= (tokenCount == '1) ? tokenCount : tokenCount + 1'b1;
          end
        end
        LOCKED: begin
          if (decIsControl) begin
            lossCount <= '0;
          end else if (lockDrop) begin
            state     <= SEARCH;
            lossCount <= '0;
            idleCount <= '0;
          end else begin
            lossCount <= (lossCount == '1) ? lossCount : lossCount + 1'b1;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

  // Decoded outputs, forced to zero whenever locked will read 0 this cycle
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      pixelReg   <= 8'h00;
      controlReg <= 2'b00;
      deReg      <= 1'b0;
    end else if (!lockedNext) begin
      pixelReg   <= 8'h00;
      controlReg <= 2'b00;
      deReg      <= 1'b0;
    end else if (decIsControl) begin
      pixelReg   <= 8'h00;
      controlReg <= decControl;
      deReg      <= 1'b0;
    end else begin
      pixelReg <= decData;
      deReg    <= 1'b1;
    end
  end

  assign bus.pixelComponent = pixelReg;
  assign bus.controlBus     = controlReg;
  assign bus.DE             = deReg;
  assign bus.bitslip        = bitslipReg;
  assign bus.locked         = lockedReg;

endmodule

// File: tb/tb_tmds_decoder_aligner.sv
// Randomised scoreboard bench for tmds_decoder_aligner. The driver feeds one
// character per cycle and pushes the reference model's expected outputs; a
// separate monitor pops and compares on every falling edge.
module tb_tmds_decoder_aligner;

  localparam int SEARCH_WINDOW = 1024;
  localparam int SLIP_SETTLE   = 4;
  localparam int LOCK_TOKENS   = 16;
  localparam int LOSS_WINDOW   = 4096;

  localparam logic [9:0] TOKENS [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};

  typedef struct packed {
    logic       locked;
    logic       slip;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] pix;
  } outExp_t;

  logic pixelClock = 1'b0;
  logic resetN;

  tmds_decoder_aligner_if bus ();

  tmds_decoder_aligner #(
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SLIP_SETTLE   (SLIP_SETTLE),
    .LOCK_TOKENS   (LOCK_TOKENS),
    .LOSS_WINDOW   (LOSS_WINDOW)
  ) dut (
    .pixelClock (pixelClock),
    .resetN     (resetN),
    .bus        (bus)
  );

  initial forever #5 pixelClock = ~pixelClock;

  outExp_t    expQ[$];
  int         assertCount = 0;
  int         failCount   = 0;
  int         cycleNum    = 0;
  logic [9:0] prevChar    = 10'd0;

  // Reference model: run lengths of tokens and quiet characters
  bit         mLocked;
  int         mStreak;
  int         mQuiet;
  int         mSettle;
  logic [1:0] mLastCtrl;

  function automatic int tokenIndex(input logic [9:0] c);
    for (int i = 0; i < 4; i++) if (c == TOKENS[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] refDecode(input logic [9:0] c);
    logic [7:0] q, x;
    q = c[9] ? ~c[7:0] : c[7:0];
    x = q ^ {q[6:0], 1'b0};
    if (!c[8]) x = ~x;
    x[0] = q[0];
    return x;
  endfunction

  function automatic logic [9:0] randData();
    logic [9:0] v;
    do v = 10'($urandom); while (tokenIndex(v) >= 0);
    return v;
  endfunction

  function automatic logic [9:0] randToken();
    return TOKENS[$urandom_range(0, 3)];
  endfunction

  task automatic modelReset();
    mLocked   = 1'b0;
    mStreak   = 0;
    mQuiet    = 0;
    mSettle   = 0;
    mLastCtrl = 2'b00;
    prevChar  = 10'd0;
    expQ.delete();
  endtask

  task automatic modelStep(input logic [9:0] c, output outExp_t e);
    int tIdx;
    tIdx = tokenIndex(c);
    e = '0;
    if (mSettle > 0) begin
      mSettle--;
      if (mSettle == 0) begin mQuiet = 0; mStreak = 0; end
    end else if (mLocked) begin
      if (tIdx >= 0) mQuiet = 0;
      else begin
        mQuiet++;
        if (mQuiet == LOSS_WINDOW) begin mLocked = 1'b0; mQuiet = 0; mStreak = 0; end
      end
    end else if (tIdx >= 0) begin
      mStreak++;
      if (mStreak == LOCK_TOKENS) begin mLocked = 1'b1; mQuiet = 0; mStreak = 0; end
    end else if (mStreak > 0) begin
      mStreak = 0;
      mQuiet  = 0;
    end else begin
      mQuiet++;
      if (mQuiet == SEARCH_WINDOW) begin e.slip = 1'b1; mQuiet = 0; mSettle = SLIP_SETTLE; end
    end
    if (mLocked) begin
      e.locked = 1'b1;
      if (tIdx >= 0) begin
        mLastCtrl = 2'(tIdx);
        e.ctrl    = mLastCtrl;
      end else begin
        e.de   = 1'b1;
        e.ctrl = mLastCtrl;
        e.pix  = refDecode(c);
      end
    end
  endtask

  // Drive one character for one clock and queue what the outputs must show
  task automatic applyStimulus(input logic [9:0] ch);
    outExp_t e;
    bus.tmdsCharacterIn = ch;
    @(posedge pixelClock);
    cycleNum++;
    modelStep(prevChar, e);
    expQ.push_back(e);
    prevChar = ch;
    #1;
  endtask

  task automatic checkOutput(input outExp_t e);
    outExp_t act;
    act = {bus.locked, bus.bitslip, bus.DE, bus.controlBus, bus.pixelComponent};
    assertCount++;
    if (act !== e) begin
      failCount++;
      $display("[TB] FAIL outputs cycle %0d: got locked=%b slip=%b DE=%b ctrl=%b pix=%h, expected locked=%b slip=%b DE=%b ctrl=%b pix=%h",
               cycleNum, act.locked, act.slip, act.de, act.ctrl, act.pix,
               e.locked, e.slip, e.de, e.ctrl, e.pix);
    end
  endtask

  task automatic checkResetValues(input string tag);
    outExp_t act;
    act = {bus.locked, bus.bitslip, bus.DE, bus.controlBus, bus.pixelComponent};
    assertCount++;
    if (act !== '0) begin
      failCount++;
      $display("[TB] FAIL %s: got locked=%b slip=%b DE=%b ctrl=%b pix=%h, expected all zero",
               tag, act.locked, act.slip, act.de, act.ctrl, act.pix);
    end
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, release later
  task automatic pulseReset(input string tag);
    @(negedge pixelClock);
    #1;
    resetN = 1'b0;
    #1;
    checkResetValues(tag);
    modelReset();
    @(posedge pixelClock);
    #2;
    resetN = 1'b1;
  endtask

  // Monitor: compare every queued expectation one half-cycle after its edge
  initial begin
    logic prevSlip;
    prevSlip = 1'b0;
    forever begin
      @(negedge pixelClock);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
      if (bus.bitslip) begin
        assertCount++;
        if (prevSlip) begin
          failCount++;
          $display("[TB] FAIL bitslip width cycle %0d: got 2 consecutive cycles high, expected 1", cycleNum);
        end
      end
      prevSlip = bus.bitslip;
    end
  end

  initial begin
    int guard;
    bus.tmdsCharacterIn = 10'd0;
    resetN = 1'b1;
    modelReset();
    #1 resetN = 1'b0;
    repeat (3) @(posedge pixelClock);
    #1;
    checkResetValues("reset state");
    @(posedge pixelClock);
    #2;
    resetN = 1'b1;

    $display("[TB] lock on a run of control tokens");
    for (int i = 0; i < 20; i++) applyStimulus(TOKENS[0]);

    $display("[TB] decode fixed and random characters while locked");
    applyStimulus(10'b0100000000);
    applyStimulus(10'b1000000000);
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 4) == 0) ? randToken() : randData());

    $display("[TB] loss of lock followed by a search window");
    for (int i = 0; i < LOSS_WINDOW + SEARCH_WINDOW + 40; i++) applyStimulus(randData());

    $display("[TB] failed verification after 10 tokens");
    for (int i = 0; i < 10; i++) applyStimulus(randToken());
    for (int i = 0; i < 30; i++) applyStimulus(randData());

    $display("[TB] periodic bitslip on a misaligned constant");
    for (int i = 0; i < 3 * (SEARCH_WINDOW + SLIP_SETTLE) + 20; i++) applyStimulus(10'b0000011111);

    $display("[TB] reset during lock and relock");
    for (int i = 0; i < LOCK_TOKENS + 4; i++) applyStimulus(randToken());
    for (int i = 0; i < 20; i++) applyStimulus(randData());
    pulseReset("reset during lock");
    for (int i = 0; i < LOCK_TOKENS - 1; i++) applyStimulus(randToken());
    applyStimulus(randData());
    for (int i = 0; i < LOCK_TOKENS + 2; i++) applyStimulus(randToken());
    for (int i = 0; i < 40; i++) applyStimulus(randData());

    $display("[TB] reset during slip settle");
    pulseReset("reset before slip run");
    guard = 0;
    while (mSettle == 0 && guard < 2 * SEARCH_WINDOW) begin
      applyStimulus(randData());
      guard++;
    end
    assertCount++;
    if (mSettle == 0) begin
      failCount++;
      $display("[TB] FAIL slip settle reached: got no slip in %0d cycles, expected one", guard);
    end
    pulseReset("reset during slip settle");
    for (int i = 0; i < SEARCH_WINDOW + SLIP_SETTLE + 10; i++) applyStimulus(randData());

    @(negedge pixelClock);
    #1;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tmds_decoder_aligner.md
TMDS_DECODER_ALIGNER -- requirements
Module: tmds_decoder_aligner

Interface
REQ-001 Parameter SEARCH_WINDOW, 1024: cycles without a control token before a bitslip is requested.
REQ-002 Parameter SLIP_SETTLE, 4: cycles to wait after a bitslip pulse before searching resumes.
REQ-003 Parameter LOCK_TOKENS, 16: consecutive control tokens required to declare lock.
REQ-004 Parameter LOSS_WINDOW, 4096: cycles without a control token while locked before lock is dropped.
REQ-005 pixelClock  in  1  sole clock; character rate; all logic on rising edge.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 tmdsCharacterIn  in  10  parallel character from the deserializer; bit 0 is the first bit received.
REQ-008 pixelComponent  out  8  decoded D[7:0].
REQ-009 controlBus  out  2  decoded {C1,C0}.
REQ-010 DE  out  1  1 = video data character, 0 = control period.
REQ-011 bitslip  out  1  single-cycle pulse asking the deserializer to shift word alignment by one bit.
REQ-012 locked  out  1  alignment achieved; decoded outputs are valid.

Function
REQ-013 Input SHALL be registered once; decoded outputs SHALL be registered; total latency is 2 pixelClock cycles from tmdsCharacterIn to outputs.
REQ-014 Control tokens (bit9..bit0) SHALL be 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11; on a match, DE=0, controlBus=token value, pixelComponent=0.
REQ-015 For any other character, DE=1 and controlBus holds its last value; q[7:0] SHALL be inverted when q[9]=1; then d[0]=q[0], and d[i]=q[i]^q[i-1] when q[8]=1, else ~(q[i]^q[i-1]), for i=1..7.
REQ-016 When locked=0, outputs SHALL be forced to DE=0, controlBus=00, pixelComponent=0.
REQ-017 The FSM SHALL have the states SEARCH, SLIP_WAIT, VERIFY and LOCKED, and it SHALL evaluate the registered input.
REQ-018 In SEARCH, a control token SHALL move the FSM to VERIFY with tokenCount=1; otherwise the idle counter increments, and on reaching SEARCH_WINDOW it pulses bitslip for 1 cycle, clears the counter and enters SLIP_WAIT.
REQ-019 SLIP_WAIT SHALL last exactly SLIP_SETTLE cycles and ignore input, then enter SEARCH with the idle counter at 0.
REQ-020 In VERIFY, each control token increments tokenCount; on reaching LOCK_TOKENS, the FSM enters LOCKED; any non-token character returns it to SEARCH with the idle counter at 0 and no bitslip.
REQ-021 In LOCKED, a control token SHALL clear the loss counter; otherwise the loss counter increments, and on reaching LOSS_WINDOW the FSM enters SEARCH (locked falls the next cycle) with no bitslip in that transition.
REQ-022 locked SHALL be a registered output, 1 exactly while state==LOCKED.
REQ-023 bitslip SHALL never be asserted on 2 consecutive cycles, and never outside the SEARCH->SLIP_WAIT transition.
REQ-024 Counters SHALL saturate rather than wrap, and they SHALL be sized with $clog2 of their parameter plus 1.

Reset
REQ-025 On resetN=0: state=SEARCH, all counters 0, bitslip=0, locked=0, DE=0, controlBus=00, pixelComponent=0, and the input register=0.
REQ-026 A reset asserted mid-lock or mid-SLIP_WAIT SHALL take effect immediately; the first bitslip after release is no earlier than SEARCH_WINDOW cycles later.

Structure
REQ-027 The four control-token constants and the state encoding SHALL live in the shared package tmds_pkg, which the encoder also uses.
REQ-028 Character decoding SHALL be the combinational sub-module tmds_char_decode, with 10-bit in and 8-bit data, 2-bit control and isControl out; the FSM and registers stay in the top module.

Verification
REQ-029 Locked with no slip: after reset, drive 20 cycles of 1101010100 -> locked=1 on cycle 18 after release; bitslip never asserted.
REQ-030 Decoding: drive 0100000000 then 1000000000 while locked -> 2 cycles later DE=1, pixelComponent=0x00, then 0xFF.
REQ-031 Slip sequence: drive a constant 0000011111 (never a token) -> bitslip pulses every SEARCH_WINDOW+SLIP_SETTLE cycles (1028), 1 cycle wide; locked stays 0.
REQ-032 Failed verification: send 10 tokens, then 1 data character -> state returns to SEARCH, locked stays 0, no bitslip.
REQ-033 Loss of lock: when locked, drive LOSS_WINDOW data characters -> locked=0, outputs are forced to 0, and no bitslip occurs until a further SEARCH_WINDOW cycles pass.
REQ-034 Reset during lock: deassert resetN for 1 cycle -> all outputs reach their reset values immediately (asynchronously), and relock requires 16 new tokens.
